// File: rtl/imp_seq_pkg.sv
// Shared types and constants for the impulse sequencer.
//   TW/FW/IW       : widths of system time, frequency words and interval fields
//   SW             : width of the blank-window sum (tblank1 + ti + tblank2)
//   CFG_TYPE_CONT  : cfg_type bit that selects continuous mode
//   state_e        : sequencer FSM states
//   cfg_t          : shadow copy of one complete impulse configuration
package imp_seq_pkg;

  localparam int unsigned TW = 64;
  localparam int unsigned FW = 48;
  localparam int unsigned IW = 32;
  localparam int unsigned SW = IW + 2;

  localparam int unsigned CFG_TYPE_CONT = 0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_ARMED = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_CHECK = ST_CHECK,
    S_ARMED = ST_ARMED,
    S_RUN   = ST_RUN,
    S_FIN   = ST_FIN
  } state_e;

  typedef struct packed {
    logic [TW-1:0] time_start;
    logic [FW-1:0] freq;
    logic [FW-1:0] freq_step;
    logic [15:0]   n_impulse;
    logic          cont;
    logic [IW-1:0] ti;
    logic [IW-1:0] tp;
    logic [IW-1:0] tblank1;
    logic [IW-1:0] tblank2;
  } cfg_t;

  // Blank window length; two extra bits so three IW-bit terms never overflow.
  function automatic logic [SW-1:0] blank_span(input logic [IW-1:0] tblank1,
                                               input logic [IW-1:0] ti,
                                               input logic [IW-1:0] tblank2);
    return SW'(tblank1) + SW'(ti) + SW'(tblank2);
  endfunction

endpackage

// File: rtl/imp_seq_period_gen.sv
// Period generator: phase counter plus IMP/BLANK window decode.
//   clk, rst      : clock, asynchronous active-high reset
//   run           : sequencer is in RUN; phase is held at 0 otherwise
//   clk_en        : advance enable
//   ti, tp        : pulse width, period length
//   tblank1/2     : blank lead / tail around the pulse
//   imp, blank    : window decode of the current phase (unregistered)
//   period_start  : phase == 0 while running
//   period_end    : phase == tp-1 while running
module imp_seq_period_gen
  import imp_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          clk_en,
  input  logic [IW-1:0] ti,
  input  logic [IW-1:0] tp,
  input  logic [IW-1:0] tblank1,
  input  logic [IW-1:0] tblank2,
  output logic          imp,
  output logic          blank,
  output logic          period_start,
  output logic          period_end
);

  logic [IW-1:0] phase;
  logic [SW-1:0] span;

  assign span = blank_span(tblank1, ti, tblank2);

  // Window compares run at SW bits so tblank1 + ti cannot wrap.
  assign imp          = (phase >= tblank1) && (SW'(phase) < (SW'(tblank1) + SW'(ti)));
  assign blank        = SW'(phase) < span;
  assign period_start = run && (phase == '0);
  assign period_end   = run && ((SW'(phase) + SW'(1)) == SW'(tp));

  // Phase restarts at 0 on every entry to RUN and on wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (clk_en) begin
      if (!run || period_end) begin
        phase <= '0;
      end else begin
        phase <= phase + IW'(1);
      end
    end
  end

endmodule

// File: rtl/impulse_sequencer.sv
// Impulse sequencer: latches a configuration from the SPI receiver, waits for
// the start time, then emits IMP/BLANK gates and a frequency load per period.
// Optional build macro IMP_SEQ_FREQ_STEP_EN: step the frequency word by
// cfg_freq_step after every completed impulse (modulo 2^FW).
//   clk, rst        : clock, asynchronous active-high reset
//   clk_en          : advance enable (cfg_wr is sampled regardless)
//   sys_time        : free-running system time
//   cfg_wr, cfg_*   : configuration strobe and fields
//   stop            : abort a running or armed sequence
//   IMP, BLANK      : impulse and receiver blanking gates
//   FREQ_OUT/FREQ_LD: frequency word and its load strobe
//   BUSY, DONE      : sequence active / end-of-sequence strobe
//   imp_cnt         : completed impulses (saturating)
//   late, cfg_err   : sticky status, cleared by cfg_wr
module impulse_sequencer
  import imp_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic [TW-1:0] sys_time,
  input  logic          cfg_wr,
  input  logic          stop,
  input  logic [TW-1:0] cfg_time_start,
  input  logic [FW-1:0] cfg_freq,
  input  logic [FW-1:0] cfg_freq_step,
  input  logic [15:0]   cfg_n_impulse,
  input  logic [7:0]    cfg_type,
  input  logic [IW-1:0] cfg_ti,
  input  logic [IW-1:0] cfg_tp,
  input  logic [IW-1:0] cfg_tblank1,
  input  logic [IW-1:0] cfg_tblank2,
  output logic          IMP,
  output logic          BLANK,
  output logic [FW-1:0] FREQ_OUT,
  output logic          FREQ_LD,
  output logic          BUSY,
  output logic          DONE,
  output logic [15:0]   imp_cnt,
  output logic          late,
  output logic          cfg_err
);

  state_e        state_q, state_nxt;
  cfg_t          cfg_q, cfg_nxt;
  logic [FW-1:0] freq_q, freq_nxt;
  logic          first_q, first_nxt;

  logic          imp_nxt, blank_nxt, freq_ld_nxt, done_nxt, busy_nxt;
  logic          late_nxt, cfg_err_nxt;
  logic [FW-1:0] freq_out_nxt;
  logic [15:0]   imp_cnt_nxt;

  logic          run, gen_imp, gen_blank, period_start, period_end;
  logic          last_impulse;

  assign run = (state_q == S_RUN);

  imp_seq_period_gen u_period_gen (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .clk_en       (clk_en),
    .ti           (cfg_q.ti),
    .tp           (cfg_q.tp),
    .tblank1      (cfg_q.tblank1),
    .tblank2      (cfg_q.tblank2),
    .imp          (gen_imp),
    .blank        (gen_blank),
    .period_start (period_start),
    .period_end   (period_end)
  );

  // Compared at 17 bits so a saturated count cannot alias a small n_impulse.
  assign last_impulse = !cfg_q.cont &&
                        ((17'(imp_cnt) + 17'd1) == 17'(cfg_q.n_impulse));

  // Next-state and next-output decode.
  always_comb begin
    state_nxt    = state_q;
    cfg_nxt      = cfg_q;
    freq_nxt     = freq_q;
    first_nxt    = first_q;
    imp_nxt      = IMP;
    blank_nxt    = BLANK;
    freq_out_nxt = FREQ_OUT;
    freq_ld_nxt  = 1'b0;
    imp_cnt_nxt  = imp_cnt;
    late_nxt     = late;
    cfg_err_nxt  = cfg_err;

    if (cfg_wr) begin
      // A new configuration always wins: abort silently and re-check.
      cfg_nxt.time_start = cfg_time_start;
      cfg_nxt.freq       = cfg_freq;
      cfg_nxt.freq_step  = cfg_freq_step;
      cfg_nxt.n_impulse  = cfg_n_impulse;
      cfg_nxt.cont       = cfg_type[CFG_TYPE_CONT];
      cfg_nxt.ti         = cfg_ti;
      cfg_nxt.tp         = cfg_tp;
      cfg_nxt.tblank1    = cfg_tblank1;
      cfg_nxt.tblank2    = cfg_tblank2;
      late_nxt           = 1'b0;
      cfg_err_nxt        = 1'b0;
      imp_cnt_nxt        = '0;
      imp_nxt            = 1'b0;
      blank_nxt          = 1'b0;
      state_nxt          = S_CHECK;
    end else if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          state_nxt = S_IDLE;
        end
        S_CHECK: begin
          if ((cfg_q.tp == '0) ||
              (blank_span(cfg_q.tblank1, cfg_q.ti, cfg_q.tblank2) > SW'(cfg_q.tp))) begin
            cfg_err_nxt = 1'b1;
            state_nxt   = S_IDLE;
          end else if ((cfg_q.n_impulse == 16'd0) && !cfg_q.cont) begin
            state_nxt = S_FIN;
          end else begin
            freq_nxt  = cfg_q.freq;
            first_nxt = 1'b1;
            state_nxt = S_ARMED;
          end
        end
        S_ARMED: begin
          first_nxt = 1'b0;
          if (stop) begin
            state_nxt = S_FIN;
          end else if (sys_time >= cfg_q.time_start) begin
            if (first_q && (sys_time > cfg_q.time_start)) begin
              late_nxt = 1'b1;
            end
            state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            imp_nxt   = 1'b0;
            blank_nxt = 1'b0;
            state_nxt = S_FIN;
          end else begin
            imp_nxt   = gen_imp;
            blank_nxt = gen_blank;
            if (period_start) begin
              freq_ld_nxt  = 1'b1;
              freq_out_nxt = freq_q;
            end
            if (period_end) begin
              imp_cnt_nxt = (imp_cnt != 16'hFFFF) ? (imp_cnt + 16'd1) : imp_cnt;
`ifdef IMP_SEQ_FREQ_STEP_EN
              freq_nxt    = freq_q + cfg_q.freq_step;
`endif
              if (last_impulse) begin
                state_nxt = S_FIN;
              end
            end
          end
        end
        S_FIN: begin
          imp_nxt   = 1'b0;
          blank_nxt = 1'b0;
          state_nxt = S_IDLE;
        end
        default: begin
          imp_nxt   = 1'b0;
          blank_nxt = 1'b0;
          state_nxt = S_IDLE;
        end
      endcase
    end

    // DONE marks entry into FIN, so it is coincident with the FIN cycle.
    done_nxt = (state_nxt == S_FIN) && (state_q != S_FIN);
    busy_nxt = (state_nxt == S_ARMED) || (state_nxt == S_RUN);
  end

  // State, shadow config and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cfg_q    <= '0;
      freq_q   <= '0;
      first_q  <= 1'b0;
      IMP      <= 1'b0;
      BLANK    <= 1'b0;
      FREQ_OUT <= '0;
      FREQ_LD  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      imp_cnt  <= '0;
      late     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cfg_q    <= cfg_nxt;
      freq_q   <= freq_nxt;
      first_q  <= first_nxt;
      IMP      <= imp_nxt;
      BLANK    <= blank_nxt;
      FREQ_OUT <= freq_out_nxt;
      FREQ_LD  <= freq_ld_nxt;
      BUSY     <= busy_nxt;
      DONE     <= done_nxt;
      imp_cnt  <= imp_cnt_nxt;
      late     <= late_nxt;
      cfg_err  <= cfg_err_nxt;
    end
  end

  // Reserved type bits (and the step word when stepping is disabled) are unused.
`ifdef IMP_SEQ_FREQ_STEP_EN
  logic unused_cfg;
  assign unused_cfg = ^cfg_type[7:1];
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_type[7:1], cfg_q.freq_step};
`endif

endmodule

// File: tb/tb_impulse_sequencer.sv
// Directed self-checking bench for impulse_sequencer.
module tb_impulse_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en = 1'b1;
  logic [63:0] sys_time;
  logic        cfg_wr, stop;
  logic [63:0] cfg_time_start;
  logic [47:0] cfg_freq, cfg_freq_step;
  logic [15:0] cfg_n_impulse;
  logic [7:0]  cfg_type;
  logic [31:0] cfg_ti, cfg_tp, cfg_tblank1, cfg_tblank2;
  logic        IMP, BLANK, FREQ_LD, BUSY, DONE, late, cfg_err;
  logic [47:0] FREQ_OUT;
  logic [15:0] imp_cnt;

  logic        en_toggle = 1'b0;
  int          n_cmp = 0;
  int          n_mis = 0;

  // Monitor state
  int          cyc = 0, n_imp = 0, n_blank = 0, n_done = 0;
  bit          busy_seen = 1'b0;
  logic        imp_d = 1'b0, blank_d = 1'b0;
  int          ld_cyc[$], imp_rise[$], imp_fall[$], blank_rise[$], blank_fall[$];
  logic [47:0] ld_val[$];
  logic [63:0] ld_time[$];

  impulse_sequencer dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .sys_time(sys_time),
    .cfg_wr(cfg_wr), .stop(stop), .cfg_time_start(cfg_time_start),
    .cfg_freq(cfg_freq), .cfg_freq_step(cfg_freq_step),
    .cfg_n_impulse(cfg_n_impulse), .cfg_type(cfg_type), .cfg_ti(cfg_ti),
    .cfg_tp(cfg_tp), .cfg_tblank1(cfg_tblank1), .cfg_tblank2(cfg_tblank2),
    .IMP(IMP), .BLANK(BLANK), .FREQ_OUT(FREQ_OUT), .FREQ_LD(FREQ_LD),
    .BUSY(BUSY), .DONE(DONE), .imp_cnt(imp_cnt), .late(late), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // System time advances in clk_en ticks.
  always @(posedge clk or posedge rst) begin
    if (rst) sys_time <= 64'd0;
    else if (clk_en) sys_time <= sys_time + 64'd1;
  end

  always @(negedge clk) clk_en = en_toggle ? ~clk_en : 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (IMP) n_imp++;
    if (BLANK) n_blank++;
    if (DONE) n_done++;
    if (BUSY) busy_seen = 1'b1;
    if (IMP && !imp_d) imp_rise.push_back(cyc);
    if (!IMP && imp_d) imp_fall.push_back(cyc);
    if (BLANK && !blank_d) blank_rise.push_back(cyc);
    if (!BLANK && blank_d) blank_fall.push_back(cyc);
    if (FREQ_LD) begin
      ld_cyc.push_back(cyc);
      ld_val.push_back(FREQ_OUT);
      ld_time.push_back(sys_time);
    end
    imp_d   = IMP;
    blank_d = BLANK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    n_imp = 0; n_blank = 0; n_done = 0; busy_seen = 1'b0;
    ld_cyc.delete(); ld_val.delete(); ld_time.delete();
    imp_rise.delete(); imp_fall.delete(); blank_rise.delete(); blank_fall.delete();
  endtask

  task automatic do_cfg(input logic [63:0] ts, input logic [47:0] f, input logic [47:0] fs,
                        input logic [15:0] n, input logic [7:0] ty, input logic [31:0] ti,
                        input logic [31:0] tp, input logic [31:0] tb1, input logic [31:0] tb2,
                        output logic [63:0] s0);
    @(negedge clk);
    cfg_time_start = ts; cfg_freq = f; cfg_freq_step = fs; cfg_n_impulse = n;
    cfg_type = ty; cfg_ti = ti; cfg_tp = tp; cfg_tblank1 = tb1; cfg_tblank2 = tb2;
    cfg_wr = 1'b1;
    s0 = sys_time;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (DONE) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] s0;
    bit ok;
    int k;
    logic [47:0] exp_f2, exp_f3;
`ifdef IMP_SEQ_FREQ_STEP_EN
    exp_f2 = 48'd3; exp_f3 = 48'd5;
`else
    exp_f2 = 48'd1; exp_f3 = 48'd1;
`endif
    rst = 1'b1; cfg_wr = 1'b0; stop = 1'b0;
    cfg_time_start = '0; cfg_freq = '0; cfg_freq_step = '0; cfg_n_impulse = '0;
    cfg_type = '0; cfg_ti = '0; cfg_tp = '0; cfg_tblank1 = '0; cfg_tblank2 = '0;
    repeat (3) @(negedge clk);
    check("rst_imp", IMP, 0);       check("rst_blank", BLANK, 0);
    check("rst_freq_out", FREQ_OUT, 0); check("rst_freq_ld", FREQ_LD, 0);
    check("rst_busy", BUSY, 0);     check("rst_done", DONE, 0);
    check("rst_imp_cnt", imp_cnt, 0); check("rst_late", late, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal: 3 impulses, ti=5 tp=20 tb1=2 tb2=3
    clear_mon();
    do_cfg(64'd100, 48'd1, 48'd2, 16'd3, 8'd0, 32'd5, 32'd20, 32'd2, 32'd3, s0);
    wait_done(400, ok);
    check("nom_done_seen", ok, 1);
    repeat (3) @(negedge clk);
    check("nom_ld_count", ld_cyc.size(), 3);
    if (ld_cyc.size() == 3 && imp_rise.size() > 0 && imp_fall.size() > 0 &&
        blank_rise.size() > 0 && blank_fall.size() > 0) begin
      check("nom_freq0", ld_val[0], 1);
      check("nom_freq1", ld_val[1], exp_f2);
      check("nom_freq2", ld_val[2], exp_f3);
      check("nom_start_time", ld_time[0], 102);
      check("nom_period", ld_cyc[1] - ld_cyc[0], 20);
      check("nom_period2", ld_cyc[2] - ld_cyc[1], 20);
      check("nom_imp_offset", imp_rise[0] - ld_cyc[0], 2);
      check("nom_imp_width", imp_fall[0] - imp_rise[0], 5);
      check("nom_blank_align", blank_rise[0] - ld_cyc[0], 0);
      check("nom_blank_width", blank_fall[0] - blank_rise[0], 10);
    end
    check("nom_imp_total", n_imp, 15);
    check("nom_blank_total", n_blank, 30);
    check("nom_done_count", n_done, 1);
    check("nom_imp_cnt", imp_cnt, 3);
    check("nom_late", late, 0);
    check("nom_busy_after", BUSY, 0);

    // Late start, S == tp boundary accepted
    clear_mon();
    do_cfg(64'd4, 48'd10, 48'd0, 16'd1, 8'd0, 32'd2, 32'd4, 32'd1, 32'd1, s0);
    wait_done(100, ok);
    check("late_done_seen", ok, 1);
    repeat (3) @(negedge clk);
    check("late_flag", late, 1);
    check("late_cfg_err", cfg_err, 0);
    check("late_ld_count", ld_cyc.size(), 1);
    if (ld_cyc.size() > 0 && imp_rise.size() > 0) begin
      check("late_start_time", ld_time[0], s0 + 64'd4);
      check("late_imp_offset", imp_rise[0] - ld_cyc[0], 1);
    end
    check("late_blank_total", n_blank, 4);
    check("late_imp_total", n_imp, 2);
    check("late_imp_cnt", imp_cnt, 1);

    // Bad configurations
    clear_mon();
    do_cfg(64'd0, 48'd0, 48'd0, 16'd1, 8'd0, 32'd5, 32'd10, 32'd3, 32'd3, s0);
    repeat (6) @(negedge clk);
    check("bad_sum_err", cfg_err, 1);
    check("bad_sum_late_clr", late, 0);
    check("bad_sum_busy", busy_seen, 0);
    check("bad_sum_done", n_done, 0);
    clear_mon();
    do_cfg(64'd0, 48'd0, 48'd0, 16'd1, 8'd0, 32'd0, 32'd0, 32'd0, 32'd0, s0);
    repeat (4) @(negedge clk);
    check("bad_tp0_err", cfg_err, 1);
    check("bad_tp0_busy", busy_seen, 0);

    // Zero impulses
    clear_mon();
    do_cfg(64'd0, 48'd0, 48'd0, 16'd0, 8'd0, 32'd3, 32'd8, 32'd1, 32'd1, s0);
    check("zero_done_early", DONE, 0);
    check("zero_err_clr", cfg_err, 0);
    @(negedge clk);
    check("zero_done", DONE, 1);
    repeat (3) @(negedge clk);
    check("zero_imp_total", n_imp, 0);
    check("zero_busy", busy_seen, 0);
    check("zero_done_count", n_done, 1);

    // Continuous mode, stop in the 5th period
    clear_mon();
    do_cfg(64'd0, 48'd0, 48'd0, 16'd0, 8'd1, 32'd2, 32'd6, 32'd1, 32'd1, s0);
    k = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (FREQ_LD) k++;
      if (k == 5) break;
    end
    check("cont_ld5", k, 5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("cont_stop_imp", IMP, 0);
    check("cont_stop_blank", BLANK, 0);
    check("cont_stop_done", DONE, 1);
    check("cont_imp_cnt", imp_cnt, 4);
    repeat (3) @(negedge clk);
    check("cont_busy_after", BUSY, 0);

    // Reconfiguration during RUN
    clear_mon();
    do_cfg(64'd0, 48'd7, 48'd0, 16'd2, 8'd0, 32'd3, 32'd10, 32'd1, 32'd1, s0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (FREQ_LD) begin ok = 1'b1; break; end
    end
    check("recfg_first_ld", ok, 1);
    do_cfg(64'd0, 48'd9, 48'd0, 16'd1, 8'd0, 32'd2, 32'd8, 32'd0, 32'd0, s0);
    check("recfg_abort_imp", IMP, 0);
    check("recfg_abort_blank", BLANK, 0);
    wait_done(100, ok);
    check("recfg_done_seen", ok, 1);
    repeat (3) @(negedge clk);
    check("recfg_done_count", n_done, 1);
    check("recfg_imp_cnt", imp_cnt, 1);
    check("recfg_ld_count", ld_cyc.size(), 2);
    if (ld_val.size() == 2) begin
      check("recfg_freq_a", ld_val[0], 7);
      check("recfg_freq_b", ld_val[1], 9);
    end

    // clk_en toggling doubles all intervals
    clear_mon();
    en_toggle = 1'b1;
    do_cfg(64'd0, 48'd0, 48'd0, 16'd2, 8'd0, 32'd3, 32'd10, 32'd2, 32'd1, s0);
    wait_done(600, ok);
    check("ce_done_seen", ok, 1);
    repeat (3) @(negedge clk);
    en_toggle = 1'b0;
    check("ce_ld_count", ld_cyc.size(), 2);
    if (ld_cyc.size() == 2 && imp_rise.size() > 0 && imp_fall.size() > 0 &&
        blank_rise.size() > 0 && blank_fall.size() > 0) begin
      check("ce_period", ld_cyc[1] - ld_cyc[0], 20);
      check("ce_imp_offset", imp_rise[0] - ld_cyc[0], 4);
      check("ce_imp_width", imp_fall[0] - imp_rise[0], 6);
      check("ce_blank_width", blank_fall[0] - blank_rise[0], 12);
    end
    check("ce_imp_total", n_imp, 12);
    check("ce_imp_cnt", imp_cnt, 2);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-pulse
    clear_mon();
    do_cfg(64'd0, 48'd5, 48'd0, 16'd3, 8'd0, 32'd4, 32'd10, 32'd1, 32'd1, s0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (IMP) begin ok = 1'b1; break; end
    end
    check("arst_imp_seen", ok, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_imp", IMP, 0);
    check("arst_blank", BLANK, 0);
    check("arst_busy", BUSY, 0);
    check("arst_freq_out", FREQ_OUT, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("arst_idle", BUSY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
